interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 The block SHALL have one clock, i_clk; reset i_rst_n SHALL be asynchronous and active-low.
REQ-002 Parameters SHALL be: MCAUSE_VAL, default 32'h8000_000B, the cause code written on trap; SYNC_STAGES, default 2, the depth of the i_irq synchronizer.
REQ-003 Ports SHALL be, as name / direction / width / meaning:
- i_clk / in / 1 / clock
- i_rst_n / in / 1 / async active-low reset
- i_irq / in / 1 / external interrupt, level, asynchronous
- i_mie / in / 1 / global machine interrupt enable (mstatus.MIE)
- i_pipe_stall / in / 1 / pipeline stall; the EX-stage register holds
- i_ex_insn_vld / in / 1 / EX stage holds a valid instruction
- i_ex_pc / in / 32 / PC of the EX-stage instruction
- i_ex_is_mret / in / 1 / EX-stage instruction is MRET
- i_mtvec / in / 32 / trap vector CSR
- i_mepc / in / 32 / current mepc CSR
- o_flush / out / 1 / flush IF/ID and ID/EX (NOP insertion, insn_vld=0)
- o_pc_redirect / out / 1 / load PC with o_redirect_pc
- o_redirect_pc / out / 32 / redirect target
- o_mepc_wren / out / 1 / mepc write strobe
- o_mepc_wdata / out / 32 / mepc write data
- o_mcause_wren / out / 1 / mcause write strobe
- o_mcause_wdata / out / 32 / mcause write data
- o_mie_clr / out / 1 / MPIE<=MIE, MIE<=0
- o_mie_restore / out / 1 / MIE<=MPIE, MPIE<=1
- o_in_handler / out / 1 / a trap is being serviced

Function
REQ-004 i_irq SHALL pass through a SYNC_STAGES flip-flop synchronizer; only the synchronized value, irq_s, SHALL be used.
REQ-005 The FSM SHALL have five states: IDLE, WAIT_VLD, TRAP, HANDLER, RETURN.
REQ-006 IDLE -> WAIT_VLD SHALL occur when irq_s=1 and i_mie=1; otherwise the FSM SHALL remain in IDLE.
REQ-007 In WAIT_VLD, if i_mie=0 or irq_s=0, the FSM SHALL return to IDLE; interrupts SHALL NOT be latched.
REQ-008 WAIT_VLD -> TRAP SHALL occur when i_ex_insn_vld=1, i_pipe_stall=0, irq_s=1 and i_mie=1; on that edge the block SHALL capture i_ex_pc into a 32-bit register, cap_pc.
REQ-009 TRAP SHALL last exactly one cycle and then go to HANDLER. During TRAP:
- o_flush=1 and o_pc_redirect=1
- o_redirect_pc={i_mtvec[31:2],2'b00}
- o_mepc_wren=1 with o_mepc_wdata=cap_pc
- o_mcause_wren=1 with o_mcause_wdata=MCAUSE_VAL
- o_mie_clr=1
REQ-010 The EX instruction captured in REQ-008 SHALL be flushed, not committed; it SHALL re-execute after return.
REQ-011 HANDLER -> RETURN SHALL occur when i_ex_insn_vld=1, i_ex_is_mret=1 and i_pipe_stall=0; irq_s SHALL be ignored while in HANDLER.
REQ-012 RETURN SHALL last exactly one cycle and then go to IDLE. During RETURN: o_flush=1, o_pc_redirect=1, o_redirect_pc=i_mepc, o_mie_restore=1.
REQ-013 o_in_handler SHALL be 1 in TRAP, HANDLER and RETURN, and 0 otherwise.
REQ-014 Every strobe output SHALL be 0 outside the states named in REQ-009 and REQ-012. o_redirect_pc, o_mepc_wdata and o_mcause_wdata SHALL be 32'h0 when their strobe is 0.
REQ-015 An MRET seen in IDLE or WAIT_VLD SHALL be ignored by this block; no redirect SHALL be issued.
REQ-016 If irq_s is still high after RETURN, the FSM SHALL re-enter WAIT_VLD no earlier than the first cycle after IDLE, provided i_mie has been restored.
REQ-017 Latency from an i_irq rising edge to TRAP SHALL be SYNC_STAGES+2 cycles minimum when the EX stage is valid and unstalled.

Reset
REQ-018 On i_rst_n=0, asynchronously:
- FSM state SHALL be IDLE
- the synchronizer flops SHALL be 0
- cap_pc SHALL be 32'h0
- all outputs SHALL be 0
REQ-019 A reset asserted in any state, including mid-TRAP or mid-RETURN, SHALL abort the operation. After reset no strobe SHALL be issued until REQ-006 is satisfied anew.

Verification
REQ-020 Basic trap: i_mie=1, EX valid with i_ex_pc=32'h0000_0100, i_mtvec=32'h0000_0203, i_irq raised -> one-cycle TRAP with:
- o_redirect_pc=32'h0000_0200
- o_mepc_wdata=32'h0000_0100
- o_mcause_wdata=32'h8000_000B
- o_flush=o_mie_clr=1
REQ-021 Stalled or bubble EX: irq_s=1 with i_pipe_stall=1 for 3 cycles, then EX invalid for 2 cycles -> FSM holds in WAIT_VLD with no strobes; TRAP occurs on the first valid, unstalled cycle.
REQ-022 Return: in HANDLER, MRET valid in EX with i_mepc=32'h0000_0100 -> one-cycle RETURN with o_redirect_pc=32'h0000_0100 and o_mie_restore=1, then IDLE with o_in_handler=0.
REQ-023 Masked and withdrawn interrupts:
- i_mie=0 with i_irq=1 -> FSM stays in IDLE
- irq drops while in WAIT_VLD -> FSM returns to IDLE with no strobe
REQ-024 Nested and pending: i_irq held high through HANDLER -> no second TRAP before RETURN; a second TRAP follows after RETURN once i_mie=1.
REQ-025 Reset mid-operation: i_rst_n pulsed low during TRAP -> all outputs are 0 immediately and the FSM is in IDLE.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
//
// Purpose:
//   Machine-mode external interrupt sequencer for a simple in-order pipeline.
//   An asynchronous level interrupt is synchronized and, when globally
//   enabled, waits for a valid, unstalled instruction in EX. That instruction
//   is flushed and its PC is saved as mepc. The PC is redirected to mtvec,
//   mcause is written and MIE is cleared. An MRET executed while the handler
//   runs flushes the pipe, redirects to mepc and restores MIE.
//
// Parameters:
//   MCAUSE_VAL   cause code written to mcause on trap entry
//   SYNC_STAGES  depth of the i_irq synchronizer (>= 1)
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_irq                  external interrupt, level, asynchronous
//   i_mie                  global machine interrupt enable (mstatus.MIE)
//   i_pipe_stall           EX-stage register is holding this cycle
//   i_ex_insn_vld          EX stage holds a valid instruction
//   i_ex_pc                PC of the EX-stage instruction
//   i_ex_is_mret           EX-stage instruction is MRET
//   i_mtvec, i_mepc        trap vector and current mepc CSR values
//   o_flush                flush IF/ID and ID/EX
//   o_pc_redirect          load PC with o_redirect_pc
//   o_redirect_pc          redirect target (0 when not redirecting)
//   o_mepc_wren/_wdata     mepc write strobe and data
//   o_mcause_wren/_wdata   mcause write strobe and data
//   o_mie_clr              MPIE<=MIE, MIE<=0
//   o_mie_restore          MIE<=MPIE, MPIE<=1
//   o_in_handler           a trap is being serviced
// -----------------------------------------------------------------------------
module interrupt_ctrl #(
  parameter logic [31:0] MCAUSE_VAL  = 32'h8000_000B,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_irq,
  input  logic        i_mie,
  input  logic        i_pipe_stall,
  input  logic        i_ex_insn_vld,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_is_mret,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic        o_flush,
  output logic        o_pc_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_mepc_wren,
  output logic [31:0] o_mepc_wdata,
  output logic        o_mcause_wren,
  output logic [31:0] o_mcause_wdata,
  output logic        o_mie_clr,
  output logic        o_mie_restore,
  output logic        o_in_handler
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VLD = 3'd1,
    ST_TRAP     = 3'd2,
    ST_HANDLER  = 3'd3,
    ST_RETURN   = 3'd4
  } state_t;

  // Trap vectors are word aligned; the two mode bits of mtvec are dropped.
  function automatic logic [31:0] align_vec(input logic [31:0] vec);
    return {vec[31:2], 2'b00};
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_irq_s;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_cap_pc;
  logic                   w_cap_en;
  logic                   w_ex_adv;

  // Interrupt synchronizer: bit 0 samples the pin, the last bit is irq_s.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_irq;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_irq_s  = r_sync[SYNC_STAGES-1];
  // The EX instruction only "moves" when it is valid and the pipe is not held.
  assign w_ex_adv = i_ex_insn_vld & ~i_pipe_stall;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Captured PC of the interrupted EX instruction, written on WAIT_VLD->TRAP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap_pc <= 32'h0;
    end else if (w_cap_en) begin
      r_cap_pc <= i_ex_pc;
    end else begin
      r_cap_pc <= r_cap_pc;
    end
  end

  // Next-state logic. Interrupts are never latched: a masked or withdrawn
  // request in WAIT_VLD simply drops back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_irq_s && i_mie) begin
          w_state_nxt = ST_WAIT_VLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_VLD: begin
        if (!w_irq_s || !i_mie) begin
          w_state_nxt = ST_IDLE;
        end else if (w_ex_adv) begin
          w_state_nxt = ST_TRAP;
          w_cap_en    = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT_VLD;
        end
      end
      ST_TRAP: begin
        w_state_nxt = ST_HANDLER;
      end
      ST_HANDLER: begin
        // irq_s is deliberately not looked at here: no nesting.
        if (w_ex_adv && i_ex_is_mret) begin
          w_state_nxt = ST_RETURN;
        end else begin
          w_state_nxt = ST_HANDLER;
        end
      end
      ST_RETURN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state. Because the state flop resets
  // asynchronously to IDLE, every output drops to 0 the moment reset asserts.
  always_comb begin
    o_flush        = 1'b0;
    o_pc_redirect  = 1'b0;
    o_redirect_pc  = 32'h0;
    o_mepc_wren    = 1'b0;
    o_mepc_wdata   = 32'h0;
    o_mcause_wren  = 1'b0;
    o_mcause_wdata = 32'h0;
    o_mie_clr      = 1'b0;
    o_mie_restore  = 1'b0;
    o_in_handler   = 1'b0;
    case (r_state)
      ST_TRAP: begin
        o_flush        = 1'b1;
        o_pc_redirect  = 1'b1;
        o_redirect_pc  = align_vec(i_mtvec);
        o_mepc_wren    = 1'b1;
        o_mepc_wdata   = r_cap_pc;
        o_mcause_wren  = 1'b1;
        o_mcause_wdata = MCAUSE_VAL;
        o_mie_clr      = 1'b1;
        o_in_handler   = 1'b1;
      end
      ST_HANDLER: begin
        o_in_handler = 1'b1;
      end
      ST_RETURN: begin
        o_flush       = 1'b1;
        o_pc_redirect = 1'b1;
        o_redirect_pc = i_mepc;
        o_mie_restore = 1'b1;
        o_in_handler  = 1'b1;
      end
      ST_IDLE, ST_WAIT_VLD: begin
        o_in_handler = 1'b0;
      end
      default: begin
        o_in_handler = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interrupt_ctrl
//
// Self-checking bench for interrupt_ctrl. A behavioural model tracks which
// service phase the controller should be in (waiting, trap cycle, handler,
// return cycle) and predicts every output each cycle from that and the
// current inputs. Directed sequences cover the named scenarios; a random
// phase then drives all inputs with $urandom, including reset pulses.
// -----------------------------------------------------------------------------
module tb_interrupt_ctrl;

  localparam int          SYNC  = 2;
  localparam logic [31:0] CAUSE = 32'h8000_000B;

  logic        clk;
  logic        rst_n;
  logic        irq;
  logic        mie;
  logic        stall;
  logic        vld;
  logic [31:0] pc;
  logic        mret;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        flush;
  logic        redir;
  logic [31:0] redir_pc;
  logic        mepc_wren;
  logic [31:0] mepc_wdata;
  logic        mcause_wren;
  logic [31:0] mcause_wdata;
  logic        mie_clr;
  logic        mie_restore;
  logic        in_handler;

  int checks = 0;
  int errors = 0;

  interrupt_ctrl #(.MCAUSE_VAL(CAUSE), .SYNC_STAGES(SYNC)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_irq          (irq),
    .i_mie          (mie),
    .i_pipe_stall   (stall),
    .i_ex_insn_vld  (vld),
    .i_ex_pc        (pc),
    .i_ex_is_mret   (mret),
    .i_mtvec        (mtvec),
    .i_mepc         (mepc),
    .o_flush        (flush),
    .o_pc_redirect  (redir),
    .o_redirect_pc  (redir_pc),
    .o_mepc_wren    (mepc_wren),
    .o_mepc_wdata   (mepc_wdata),
    .o_mcause_wren  (mcause_wren),
    .o_mcause_wdata (mcause_wdata),
    .o_mie_clr      (mie_clr),
    .o_mie_restore  (mie_restore),
    .o_in_handler   (in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_waiting;   // interrupt accepted, waiting for an EX slot
  bit          m_trap;      // this cycle is the trap-entry cycle
  bit          m_isr;       // handler code is running
  bit          m_ret;       // this cycle is the return cycle
  logic [31:0] m_cap;       // PC of the flushed instruction
  bit          irq_hist[$]; // raw irq samples, oldest first

  task automatic model_reset();
    m_waiting = 1'b0; m_trap = 1'b0; m_isr = 1'b0; m_ret = 1'b0;
    m_cap = 32'h0;
    irq_hist.delete();
    for (int i = 0; i < SYNC; i++) irq_hist.push_back(1'b0);
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit s;
    bit go_ex;
    s = irq_hist[0];
    void'(irq_hist.pop_front());
    irq_hist.push_back(irq);
    go_ex = vld && !stall;
    if (m_trap) begin
      m_trap = 1'b0; m_isr = 1'b1;
    end else if (m_ret) begin
      m_ret = 1'b0;
    end else if (m_isr) begin
      if (go_ex && mret) begin m_isr = 1'b0; m_ret = 1'b1; end
    end else if (m_waiting) begin
      if (!(s && mie)) m_waiting = 1'b0;
      else if (go_ex) begin m_waiting = 1'b0; m_trap = 1'b1; m_cap = pc; end
    end else begin
      m_waiting = s && mie;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("flush",       {31'd0, flush},       {31'd0, m_trap | m_ret});
    check_val("redirect",    {31'd0, redir},       {31'd0, m_trap | m_ret});
    check_val("redirect_pc", redir_pc, m_trap ? (mtvec & 32'hFFFF_FFFC) : (m_ret ? mepc : 32'h0));
    check_val("mepc_wren",   {31'd0, mepc_wren},   {31'd0, m_trap});
    check_val("mepc_wdata",  mepc_wdata, m_trap ? m_cap : 32'h0);
    check_val("mcause_wren", {31'd0, mcause_wren}, {31'd0, m_trap});
    check_val("mcause_wdata", mcause_wdata, m_trap ? 32'h8000_000B : 32'h0);
    check_val("mie_clr",     {31'd0, mie_clr},     {31'd0, m_trap});
    check_val("mie_restore", {31'd0, mie_restore}, {31'd0, m_ret});
    check_val("in_handler",  {31'd0, in_handler},  {31'd0, m_trap | m_isr | m_ret});
  endtask

  // One cycle: edge, model update, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val({tag, "_in_handler"}, {31'd0, in_handler}, 32'd0);
    check_val({tag, "_strobes"},
              {22'd0, flush, redir, mepc_wren, mcause_wren, mie_clr, mie_restore,
               |redir_pc, |mepc_wdata, |mcause_wdata, in_handler}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_quiet();
    irq = 1'b0; mie = 1'b1; stall = 1'b0; vld = 1'b1;
    pc = 32'h0000_0100; mret = 1'b0; mtvec = 32'h0000_0203; mepc = 32'h0000_0100;
  endtask

  initial begin
    int n;
    bit hit;
    set_quiet();
    rst_n = 1'b0;
    model_reset();
    #3;
    check_outputs();                       // reset state
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Basic trap and latency from the irq rising edge.
    irq = 1'b1;
    n = 0; hit = 1'b0;
    while (!hit && n < 20) begin
      step(); n++;
      if (mepc_wren === 1'b1) hit = 1'b1;
    end
    check_val("irq_latency", n, SYNC + 2);
    check_val("trap_redirect_pc", redir_pc, 32'h0000_0200);
    check_val("trap_mepc", mepc_wdata, 32'h0000_0100);
    check_val("trap_mcause", mcause_wdata, 32'h8000_000B);
    // Handler with irq still high: no second trap until MRET.
    for (int i = 0; i < 6; i++) step();
    check_val("no_nested_trap", {31'd0, in_handler}, 32'd1);
    mret = 1'b1;
    step();
    check_val("ret_redirect_pc", redir_pc, 32'h0000_0100);
    check_val("ret_restore", {31'd0, mie_restore}, 32'd1);
    mret = 1'b0;
    step();
    check_val("ret_idle", {31'd0, in_handler}, 32'd0);
    // irq still pending: a second trap must follow.
    n = 0; hit = 1'b0;
    while (!hit && n < 20) begin
      step(); n++;
      if (mepc_wren === 1'b1) hit = 1'b1;
    end
    check_val("second_trap", {31'd0, hit}, 32'd1);
    // Reset in the middle of the trap cycle.
    reset_pulse("rst_trap");
    irq = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Stalled, then bubble EX: hold in WAIT_VLD, trap on first usable slot.
    irq = 1'b1; stall = 1'b1; pc = 32'h0000_0400;
    for (int i = 0; i < SYNC + 4; i++) step();
    stall = 1'b0; vld = 1'b0;
    for (int i = 0; i < 2; i++) step();
    check_val("bubble_no_trap", {31'd0, mepc_wren}, 32'd0);
    vld = 1'b1;
    step();
    check_val("stall_trap", {31'd0, mepc_wren}, 32'd1);
    check_val("stall_trap_pc", mepc_wdata, 32'h0000_0400);
    step();
    mret = 1'b1; mepc = 32'h0000_0404;
    step();
    mret = 1'b0; irq = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Masked interrupt, then withdrawn interrupt.
    mie = 1'b0; irq = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_val("masked_idle", {31'd0, in_handler}, 32'd0);
    mie = 1'b1; vld = 1'b0;
    for (int i = 0; i < 2; i++) step();
    irq = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vld = 1'b1;
    step();
    check_val("withdrawn_no_trap", {31'd0, mepc_wren}, 32'd0);
    // MRET outside the handler is ignored.
    mret = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_val("stray_mret", {31'd0, redir}, 32'd0);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) irq = ~irq;
      mie   = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 3) == 0);
      vld   = ($urandom_range(0, 4) != 0);
      mret  = ($urandom_range(0, 5) == 0);
      pc    = $urandom;
      mtvec = $urandom;
      mepc  = $urandom;
      step();
      if ((m_trap || m_ret) && $urandom_range(0, 9) == 0) reset_pulse("rst_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
